rom_arbiter: RTL and testbench
==============================

// Module: rom_arbiter
// PURPOSE
//   Shares one synchronous 16-bit instrument/envelope ROM between NUM_PORTS clients,
//   for example the per-channel envelope generators and the sequencer.
//   Uses registered round-robin arbitration. Accepts at most one ROM access per
//   cycle, and returns each read to its requester exactly two cycles after the
//   request is accepted.
//   Sits between the channel blocks and the ROM instance. Clients never drive the
//   ROM address directly.
// PARAMETERS
//   NUM_PORTS   4    number of requesting clients (2..8)
//   ADDR_WIDTH  8    ROM word-address width
//   DATA_WIDTH  16   ROM word width
// PORTS
//   i_clk       in   1                     system clock
//   i_rst_n     in   1                     reset, asynchronous, active-low
//   i_req       in   NUM_PORTS             per-port read request; hold high until o_gnt seen
//   i_addr      in   NUM_PORTS*ADDR_WIDTH  per-port address; port p = [p*ADDR_WIDTH +: ADDR_WIDTH]; stable while i_req high
//   o_gnt       out  NUM_PORTS             one-hot, 1-cycle pulse: request accepted this cycle
//   o_rvalid    out  NUM_PORTS             one-hot, 1-cycle pulse: o_rdata belongs to this port
//   o_rdata     out  DATA_WIDTH            read data, shared by all ports; qualify with o_rvalid
//   o_rom_addr  out  ADDR_WIDTH            address to ROM (registered)
//   o_rom_en    out  1                     ROM read enable (registered)
//   i_rom_data  in   DATA_WIDTH            ROM output; valid the cycle after o_rom_en
// BEHAVIOUR
//   Reset (async, i_rst_n=0)
//   - o_gnt=0, o_rvalid=0, o_rom_en=0, o_rom_addr=0.
//   - Priority pointer = 0. Any in-flight read is discarded; no rvalid is ever produced for it.
//   - Release is synchronous to i_clk.
//   Arbitration (every cycle, combinational, on sampled i_req)
//   - Candidate set = i_req & ~o_gnt. The port granted this cycle is masked, so a
//     request still held high in its grant cycle is not granted twice.
//   - Search starts at the pointer index and walks upward, wrapping at NUM_PORTS-1 -> 0.
//     The first candidate found wins.
//   - No candidate: next cycle o_gnt=0, o_rom_en=0; o_rom_addr holds its previous value.
//   Timing for a request accepted at edge E (arbitration cycle N)
//   - cycle N+1: o_gnt[g]=1, o_rom_en=1, o_rom_addr = addr of port g.
//     Pointer becomes (g+1) mod NUM_PORTS.
//   - cycle N+2: o_rvalid[g]=1, o_rdata = i_rom_data.
//     o_rdata is a direct pass-through of i_rom_data; o_rvalid is a registered copy of o_gnt.
//   - Throughput: one grant per cycle across distinct ports; grants may be back-to-back.
//   - A single port re-requesting continuously gets at most one grant every 2 cycles (N+1, N+3, ...).
//   Client rule
//   - Drop i_req, or present a new address, in the cycle after o_gnt.
//   - Changing i_addr while i_req=1 and o_gnt=0 is illegal; flag it with an assertion in
//     simulation only.
//   Fairness
//   - With K ports requesting continuously, each port is granted within K grant cycles.
//   - No starvation.
//   Pipeline state
//   - gnt_q (grant register) -> rvalid_q (return register).
//   - Both registers are one-hot or zero.
//   - o_rvalid and o_gnt may be high together for different ports.
//   Mid-operation reset
//   - Outputs drop asynchronously.
//   - After release the first grant occurs no earlier than 1 cycle after a sampled request.
//   No address range checking; out-of-range reads return whatever the ROM returns.
// TESTING
//   1. Single read: port 2 requests addr 0x05, ROM[0x05]=0xA5A5 -> o_gnt=4'b0100 and
//      o_rom_addr=0x05 next cycle; o_rvalid=4'b0100 and o_rdata=0xA5A5 the cycle after.
//   2. All four ports request together after reset -> grants to 0,1,2,3 on consecutive
//      cycles; rvalid 0..3 each one cycle later; correct data per port.
//   3. Ports 1 and 3 request continuously, re-asserting after each grant -> grants
//      alternate 1,3,1,3; no port is granted twice while the other waits.
//   4. Port 0 alone requests continuously -> o_gnt[0] on cycles N+1, N+3, N+5 only;
//      never on consecutive cycles.
//   5. i_rst_n pulsed low between gnt[1] and rvalid[1] -> o_rvalid stays 0 throughout.
//      After release, ports 0 and 2 request -> port 0 granted first.
//   6. NUM_PORTS=2 instance, pointer at 1, both ports requesting -> grant 1 then 0
//      (wrap-around); ROM address matches the granted port each cycle.

Source files
------------

// File: rtl/rom_arbiter.sv
// rom_arbiter: round-robin sharing of one synchronous ROM between NUM_PORTS clients.
// A request accepted at an edge shows as a one-cycle o_gnt pulse together with the
// ROM address/enable; the read data returns with a one-cycle o_rvalid pulse one
// cycle later.
// Ports:
//   i_clk, i_rst_n         clock, asynchronous active-low reset
//   i_req, i_addr          per-port request and packed per-port word address
//   o_gnt                  one-hot grant pulse (registered)
//   o_rvalid, o_rdata      one-hot return pulse (registered) and shared read data
//   o_rom_addr, o_rom_en   registered ROM address and read enable
//   i_rom_data             ROM output, valid the cycle after o_rom_en
module rom_arbiter #(
  parameter int unsigned NUM_PORTS  = 4,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic [NUM_PORTS-1:0]            i_req,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] i_addr,
  output logic [NUM_PORTS-1:0]            o_gnt,
  output logic [NUM_PORTS-1:0]            o_rvalid,
  output logic [DATA_WIDTH-1:0]           o_rdata,
  output logic [ADDR_WIDTH-1:0]           o_rom_addr,
  output logic                            o_rom_en,
  input  logic [DATA_WIDTH-1:0]           i_rom_data
);

  localparam int unsigned PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [PTR_W-1:0]      ptr_q, ptr_d;
  logic [NUM_PORTS-1:0]  gnt_q, gnt_d;
  logic [NUM_PORTS-1:0]  rvalid_q, rvalid_d;
  logic [ADDR_WIDTH-1:0] rom_addr_q, rom_addr_d;
  logic                  rom_en_q, rom_en_d;

  logic [ADDR_WIDTH-1:0] port_addr [NUM_PORTS];
  logic [NUM_PORTS-1:0]  cand;
  logic [PTR_W-1:0]      win_idx;
  logic                  win_found;
  int unsigned           scan;

  // Unpack the flat address bus into one word per port
  always_comb begin
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      port_addr[p] = i_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
    end
  end

  // The port already holding this cycle's grant is masked so a held request is not taken twice
  assign cand = i_req & ~gnt_q;

  // Round-robin search: start at the pointer, walk upward with wrap, first candidate wins
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan      = 0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      scan = (32'(ptr_q) + i) % NUM_PORTS;
      if (!win_found && cand[PTR_W'(scan)]) begin
        win_found = 1'b1;
        win_idx   = PTR_W'(scan);
      end
    end
  end

  // Next-state: grant stage loads from the search, return stage copies the grant stage
  always_comb begin
    gnt_d      = '0;
    rom_en_d   = 1'b0;
    rom_addr_d = rom_addr_q;
    ptr_d      = ptr_q;
    rvalid_d   = gnt_q;
    if (win_found) begin
      gnt_d[win_idx] = 1'b1;
      rom_en_d       = 1'b1;
      rom_addr_d     = port_addr[win_idx];
      ptr_d          = (32'(win_idx) + 32'd1 >= NUM_PORTS) ? '0 : win_idx + PTR_W'(1);
    end
  end

  // Pipeline registers; reset drops any in-flight read
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ptr_q      <= '0;
      gnt_q      <= '0;
      rvalid_q   <= '0;
      rom_addr_q <= '0;
      rom_en_q   <= 1'b0;
    end else begin
      ptr_q      <= ptr_d;
      gnt_q      <= gnt_d;
      rvalid_q   <= rvalid_d;
      rom_addr_q <= rom_addr_d;
      rom_en_q   <= rom_en_d;
    end
  end

  assign o_gnt      = gnt_q;
  assign o_rvalid   = rvalid_q;
  assign o_rom_addr = rom_addr_q;
  assign o_rom_en   = rom_en_q;
  // ROM data arrives exactly in the rvalid cycle, so it is passed straight through
  assign o_rdata    = i_rom_data;

  // Simulation checks: pipeline stages stay one-hot and the enable tracks the grant
  a_gnt_onehot: assert property (@(posedge i_clk) disable iff (!i_rst_n) $onehot0(gnt_q));
  a_rvalid_onehot: assert property (@(posedge i_clk) disable iff (!i_rst_n) $onehot0(rvalid_q));
  a_en_matches_gnt: assert property (@(posedge i_clk) disable iff (!i_rst_n) rom_en_q == (|gnt_q));

  // A waiting client (request held, not yet granted) must keep its address stable
  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_addr_chk
    a_addr_stable: assert property (@(posedge i_clk) disable iff (!i_rst_n)
      ($past(i_req[p]) && !$past(gnt_q[p]) && i_req[p])
        |-> $stable(i_addr[p*ADDR_WIDTH +: ADDR_WIDTH]));
  end

endmodule

// File: tb/tb_rom_arbiter.sv
// tb_rom_arbiter: scoreboard bench for rom_arbiter (4-port and 2-port instances).
module tb_rom_arbiter;

  localparam int unsigned NP = 4;
  localparam int unsigned AW = 8;
  localparam int unsigned DW = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NP-1:0]    req = '0;
  logic [NP*AW-1:0] addr = '0;
  logic [NP-1:0]    gnt, rvalid;
  logic [DW-1:0]    rdata, rom_data;
  logic [AW-1:0]    rom_addr;
  logic             rom_en;

  logic [1:0]       req2 = '0;
  logic [2*AW-1:0]  addr2 = '0;
  logic [1:0]       gnt2, rvalid2;
  logic [DW-1:0]    rdata2, rom_data2;
  logic [AW-1:0]    rom_addr2;
  logic             rom_en2;

  rom_arbiter #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_addr(addr),
    .o_gnt(gnt), .o_rvalid(rvalid), .o_rdata(rdata),
    .o_rom_addr(rom_addr), .o_rom_en(rom_en), .i_rom_data(rom_data)
  );

  rom_arbiter #(.NUM_PORTS(2), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req2), .i_addr(addr2),
    .o_gnt(gnt2), .o_rvalid(rvalid2), .o_rdata(rdata2),
    .o_rom_addr(rom_addr2), .o_rom_en(rom_en2), .i_rom_data(rom_data2)
  );

  function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
    if (a == 8'h05) return 16'hA5A5;
    return {~a, a ^ 8'h3C};
  endfunction

  // Synchronous ROM models: data valid the cycle after the enable
  always @(posedge clk) if (rom_en)  rom_data  <= rom_word(rom_addr);
  always @(posedge clk) if (rom_en2) rom_data2 <= rom_word(rom_addr2);

  int n_cmp = 0;
  int n_err = 0;

  // Client model: cnt = reads still to issue, tab = address list per port
  int          cnt [NP];
  int          idx [NP];
  logic [AW-1:0] tab [NP][8];
  logic [NP-1:0] pop = '0;

  logic [NP-1:0] obs_gnt, obs_rvalid;
  logic [DW-1:0] obs_rdata;
  logic [AW-1:0] obs_raddr;
  logic          obs_en;

  typedef struct {
    int            port;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int            cyc;
  } exp_t;

  exp_t gq[$];
  exp_t rq[$];
  exp_t e;
  logic [NP-1:0] exp_g, exp_v;

  task automatic push_gnt(input int port, input logic [AW-1:0] a, input int cyc);
    exp_t x;
    x.port = port; x.a = a; x.d = rom_word(a); x.cyc = cyc;
    gq.push_back(x);
  endtask

  // One cycle: drive client inputs just after the edge, sample outputs on the falling edge
  task automatic step();
    @(posedge clk);
    #1;
    for (int p = 0; p < NP; p++) begin
      if (pop[p] && cnt[p] > 0) begin
        cnt[p]--;
        idx[p]++;
      end
      req[p] = (cnt[p] > 0);
      if (cnt[p] > 0) addr[p*AW +: AW] = tab[p][idx[p]];
    end
    @(negedge clk);
    obs_gnt    = gnt;
    obs_rvalid = rvalid;
    obs_rdata  = rdata;
    obs_raddr  = rom_addr;
    obs_en     = rom_en;
    pop        = gnt;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    req2  = '0;
    pop   = '0;
    for (int p = 0; p < NP; p++) begin cnt[p] = 0; idx[p] = 0; end
    gq.delete();
    rq.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    n_cmp++; if (gnt !== '0)      begin n_err++; $display("FAIL reset_gnt: got %b, expected 0", gnt); end
    n_cmp++; if (rvalid !== '0)   begin n_err++; $display("FAIL reset_rvalid: got %b, expected 0", rvalid); end
    n_cmp++; if (rom_en !== 1'b0) begin n_err++; $display("FAIL reset_rom_en: got %b, expected 0", rom_en); end
    n_cmp++; if (rom_addr !== '0) begin n_err++; $display("FAIL reset_rom_addr: got %h, expected 0", rom_addr); end
    n_cmp++; if (gnt2 !== '0 || rvalid2 !== '0 || rom_en2 !== 1'b0 || rom_addr2 !== '0) begin
      n_err++; $display("FAIL reset_2port: gnt %b rvalid %b en %b addr %h, expected all 0", gnt2, rvalid2, rom_en2, rom_addr2);
    end
    do_reset();
  endtask

  task automatic test_single_read();
    do_reset();
    cnt[2] = 1; tab[2][0] = 8'h05;
    push_gnt(2, 8'h05, 1);
    for (int t = 0; t < 4; t++) begin
      step();
      exp_g = '0; exp_v = '0;
      if (gq.size() > 0 && gq[0].cyc == t) exp_g[gq[0].port] = 1'b1;
      if (rq.size() > 0 && rq[0].cyc == t) exp_v[rq[0].port] = 1'b1;
      n_cmp++; if (obs_gnt !== exp_g) begin n_err++; $display("FAIL single_gnt t=%0d: got %b, expected %b", t, obs_gnt, exp_g); end
      n_cmp++; if (obs_rvalid !== exp_v) begin n_err++; $display("FAIL single_rvalid t=%0d: got %b, expected %b", t, obs_rvalid, exp_v); end
      n_cmp++; if (obs_en !== (exp_g != '0)) begin n_err++; $display("FAIL single_en t=%0d: got %b, expected %b", t, obs_en, exp_g != '0); end
      if (exp_g != '0) begin
        e = gq.pop_front();
        n_cmp++; if (obs_raddr !== e.a) begin n_err++; $display("FAIL single_addr t=%0d: got %h, expected %h", t, obs_raddr, e.a); end
        e.cyc = t + 1; rq.push_back(e);
      end
      if (exp_v != '0) begin
        e = rq.pop_front();
        n_cmp++; if (obs_rdata !== e.d) begin n_err++; $display("FAIL single_data t=%0d: got %h, expected %h", t, obs_rdata, e.d); end
      end
    end
  endtask

  task automatic test_all_ports();
    do_reset();
    for (int p = 0; p < NP; p++) begin
      cnt[p] = 1; tab[p][0] = 8'h10 + 8'(p);
      push_gnt(p, 8'h10 + 8'(p), p + 1);
    end
    for (int t = 0; t < 7; t++) begin
      step();
      exp_g = '0; exp_v = '0;
      if (gq.size() > 0 && gq[0].cyc == t) exp_g[gq[0].port] = 1'b1;
      if (rq.size() > 0 && rq[0].cyc == t) exp_v[rq[0].port] = 1'b1;
      n_cmp++; if (obs_gnt !== exp_g) begin n_err++; $display("FAIL all_gnt t=%0d: got %b, expected %b", t, obs_gnt, exp_g); end
      n_cmp++; if (obs_rvalid !== exp_v) begin n_err++; $display("FAIL all_rvalid t=%0d: got %b, expected %b", t, obs_rvalid, exp_v); end
      n_cmp++; if (obs_en !== (exp_g != '0)) begin n_err++; $display("FAIL all_en t=%0d: got %b, expected %b", t, obs_en, exp_g != '0); end
      if (exp_g != '0) begin
        e = gq.pop_front();
        n_cmp++; if (obs_raddr !== e.a) begin n_err++; $display("FAIL all_addr t=%0d: got %h, expected %h", t, obs_raddr, e.a); end
        e.cyc = t + 1; rq.push_back(e);
      end
      if (exp_v != '0) begin
        e = rq.pop_front();
        n_cmp++; if (obs_rdata !== e.d) begin n_err++; $display("FAIL all_data t=%0d: got %h, expected %h", t, obs_rdata, e.d); end
      end
    end
  endtask

  task automatic test_alternate();
    do_reset();
    cnt[1] = 3; cnt[3] = 3;
    for (int k = 0; k < 3; k++) begin
      tab[1][k] = 8'h20 + 8'(k);
      tab[3][k] = 8'h30 + 8'(k);
      push_gnt(1, 8'h20 + 8'(k), 2*k + 1);
      push_gnt(3, 8'h30 + 8'(k), 2*k + 2);
    end
    for (int t = 0; t < 9; t++) begin
      step();
      exp_g = '0; exp_v = '0;
      if (gq.size() > 0 && gq[0].cyc == t) exp_g[gq[0].port] = 1'b1;
      if (rq.size() > 0 && rq[0].cyc == t) exp_v[rq[0].port] = 1'b1;
      n_cmp++; if (obs_gnt !== exp_g) begin n_err++; $display("FAIL alt_gnt t=%0d: got %b, expected %b", t, obs_gnt, exp_g); end
      n_cmp++; if (obs_rvalid !== exp_v) begin n_err++; $display("FAIL alt_rvalid t=%0d: got %b, expected %b", t, obs_rvalid, exp_v); end
      if (exp_g != '0) begin
        e = gq.pop_front();
        n_cmp++; if (obs_raddr !== e.a) begin n_err++; $display("FAIL alt_addr t=%0d: got %h, expected %h", t, obs_raddr, e.a); end
        e.cyc = t + 1; rq.push_back(e);
      end
      if (exp_v != '0) begin
        e = rq.pop_front();
        n_cmp++; if (obs_rdata !== e.d) begin n_err++; $display("FAIL alt_data t=%0d: got %h, expected %h", t, obs_rdata, e.d); end
      end
    end
  endtask

  task automatic test_single_port_rate();
    do_reset();
    cnt[0] = 3;
    for (int k = 0; k < 3; k++) begin
      tab[0][k] = 8'h80 + 8'(k);
      push_gnt(0, 8'h80 + 8'(k), 2*k + 1);
    end
    for (int t = 0; t < 8; t++) begin
      step();
      exp_g = '0; exp_v = '0;
      if (gq.size() > 0 && gq[0].cyc == t) exp_g[gq[0].port] = 1'b1;
      if (rq.size() > 0 && rq[0].cyc == t) exp_v[rq[0].port] = 1'b1;
      n_cmp++; if (obs_gnt !== exp_g) begin n_err++; $display("FAIL rate_gnt t=%0d: got %b, expected %b", t, obs_gnt, exp_g); end
      n_cmp++; if (obs_rvalid !== exp_v) begin n_err++; $display("FAIL rate_rvalid t=%0d: got %b, expected %b", t, obs_rvalid, exp_v); end
      n_cmp++; if (obs_en !== (exp_g != '0)) begin n_err++; $display("FAIL rate_en t=%0d: got %b, expected %b", t, obs_en, exp_g != '0); end
      if (exp_g != '0) begin
        e = gq.pop_front();
        n_cmp++; if (obs_raddr !== e.a) begin n_err++; $display("FAIL rate_addr t=%0d: got %h, expected %h", t, obs_raddr, e.a); end
        e.cyc = t + 1; rq.push_back(e);
      end
      if (exp_v != '0) begin
        e = rq.pop_front();
        n_cmp++; if (obs_rdata !== e.d) begin n_err++; $display("FAIL rate_data t=%0d: got %h, expected %h", t, obs_rdata, e.d); end
      end
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    cnt[1] = 1; tab[1][0] = 8'h22;
    step();
    n_cmp++; if (obs_gnt !== 4'b0000) begin n_err++; $display("FAIL midrst_pre_gnt: got %b, expected 0000", obs_gnt); end
    step();
    n_cmp++; if (obs_gnt !== 4'b0010 || obs_raddr !== 8'h22) begin
      n_err++; $display("FAIL midrst_gnt1: got %b/%h, expected 0010/22", obs_gnt, obs_raddr);
    end
    #1;
    rst_n = 1'b0;
    req = '0; pop = '0;
    for (int p = 0; p < NP; p++) begin cnt[p] = 0; idx[p] = 0; end
    #1;
    n_cmp++; if (gnt !== '0 || rvalid !== '0 || rom_en !== 1'b0 || rom_addr !== '0) begin
      n_err++; $display("FAIL midrst_async: gnt %b rvalid %b en %b addr %h, expected all 0", gnt, rvalid, rom_en, rom_addr);
    end
    @(posedge clk); #1;
    n_cmp++; if (rvalid !== '0) begin n_err++; $display("FAIL midrst_rvalid_in_reset: got %b, expected 0", rvalid); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int t = 0; t < 2; t++) begin
      step();
      n_cmp++; if (obs_rvalid !== '0 || obs_gnt !== '0) begin
        n_err++; $display("FAIL midrst_quiet t=%0d: gnt %b rvalid %b, expected 0/0", t, obs_gnt, obs_rvalid);
      end
    end
    cnt[0] = 1; tab[0][0] = 8'h40;
    cnt[2] = 1; tab[2][0] = 8'h42;
    step();
    n_cmp++; if (obs_gnt !== 4'b0000) begin n_err++; $display("FAIL midrst_latency: got %b, expected 0000", obs_gnt); end
    step();
    n_cmp++; if (obs_gnt !== 4'b0001 || obs_raddr !== 8'h40) begin
      n_err++; $display("FAIL midrst_first: got %b/%h, expected 0001/40", obs_gnt, obs_raddr);
    end
    step();
    n_cmp++; if (obs_gnt !== 4'b0100 || obs_raddr !== 8'h42) begin
      n_err++; $display("FAIL midrst_second: got %b/%h, expected 0100/42", obs_gnt, obs_raddr);
    end
    n_cmp++; if (obs_rvalid !== 4'b0001 || obs_rdata !== rom_word(8'h40)) begin
      n_err++; $display("FAIL midrst_ret0: got %b/%h, expected 0001/%h", obs_rvalid, obs_rdata, rom_word(8'h40));
    end
    step();
    n_cmp++; if (obs_rvalid !== 4'b0100 || obs_rdata !== rom_word(8'h42)) begin
      n_err++; $display("FAIL midrst_ret2: got %b/%h, expected 0100/%h", obs_rvalid, obs_rdata, rom_word(8'h42));
    end
  endtask

  task automatic test_two_port_wrap();
    do_reset();
    @(posedge clk); #1;
    req2 = 2'b01; addr2 = {8'h00, 8'h10};
    @(negedge clk);
    n_cmp++; if (gnt2 !== 2'b00) begin n_err++; $display("FAIL wrap_c0: got %b, expected 00", gnt2); end
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++; if (gnt2 !== 2'b01 || rom_addr2 !== 8'h10) begin
      n_err++; $display("FAIL wrap_c1: got %b/%h, expected 01/10", gnt2, rom_addr2);
    end
    @(posedge clk); #1;
    req2 = 2'b11; addr2 = {8'h31, 8'h30};
    @(negedge clk);
    n_cmp++; if (gnt2 !== 2'b00 || rvalid2 !== 2'b01 || rdata2 !== rom_word(8'h10)) begin
      n_err++; $display("FAIL wrap_c2: gnt %b rvalid %b data %h, expected 00/01/%h", gnt2, rvalid2, rdata2, rom_word(8'h10));
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++; if (gnt2 !== 2'b10 || rom_addr2 !== 8'h31) begin
      n_err++; $display("FAIL wrap_c3: got %b/%h, expected 10/31", gnt2, rom_addr2);
    end
    @(posedge clk); #1;
    req2 = 2'b01;
    @(negedge clk);
    n_cmp++; if (gnt2 !== 2'b01 || rom_addr2 !== 8'h30) begin
      n_err++; $display("FAIL wrap_c4: got %b/%h, expected 01/30", gnt2, rom_addr2);
    end
    n_cmp++; if (rvalid2 !== 2'b10 || rdata2 !== rom_word(8'h31)) begin
      n_err++; $display("FAIL wrap_ret1: got %b/%h, expected 10/%h", rvalid2, rdata2, rom_word(8'h31));
    end
    @(posedge clk); #1;
    req2 = 2'b00;
    @(negedge clk);
    n_cmp++; if (gnt2 !== 2'b00 || rvalid2 !== 2'b01 || rdata2 !== rom_word(8'h30)) begin
      n_err++; $display("FAIL wrap_c5: gnt %b rvalid %b data %h, expected 00/01/%h", gnt2, rvalid2, rdata2, rom_word(8'h30));
    end
  endtask

  initial begin
    for (int p = 0; p < NP; p++) begin cnt[p] = 0; idx[p] = 0; end
    test_reset();
    test_single_read();
    test_all_ports();
    test_alternate();
    test_single_port_rate();
    test_mid_reset();
    test_two_port_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
